hamming74_byte_assembler: RTL and testbench
===========================================

Name: hamming74_byte_assembler

Overview:
- Sits directly downstream of the Hamming(7,4)+overall-parity decoder.
- Consumes one decoded 4-bit nibble per transfer, together with that nibble's decoder error flags.
- Pairs nibbles into bytes, low nibble first, and presents each byte on a valid/ready output with per-byte error status.
- Keeps saturating error/byte statistics counters for the link-health registers.

Parameters:
- CNT_W, 16, width of each statistics counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  nibble and flags valid.
- in_ready  output  1  assembler accepts the nibble this cycle.
- in_sof  input  1  start-of-frame: the accepted nibble is forced to be a low nibble.
- in_nibble  input  4  decoded data nibble.
- in_1bit_error  input  1  decoder corrected a single-bit error.
- in_2bit_error  input  1  decoder detected an uncorrectable double error.
- in_parity_error  input  1  only the overall parity bit was wrong.
- out_valid  output  1  assembled byte valid.
- out_ready  input  1  consumer accepts the byte.
- out_byte  output  8  {high nibble, low nibble}.
- out_corrected  output  1  either nibble had a 1-bit or parity error.
- out_uncorrectable  output  1  either nibble had a 2-bit error.
- clr_counts  input  1  synchronous clear of all counters.
- cnt_corrected  output  CNT_W  nibbles with in_1bit_error or in_parity_error.
- cnt_uncorrectable  output  CNT_W  nibbles with in_2bit_error.
- cnt_bytes  output  CNT_W  bytes delivered (out_valid & out_ready).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = LO.
  - out_valid, out_byte, out_corrected, out_uncorrectable = 0.
  - All counters = 0.
  - Low-nibble holding register and its flags = 0.
- Accept = in_valid & in_ready.
- in_ready = (state==LO) | ~out_valid | out_ready.
  - A low nibble can always be captured.
  - A high nibble is accepted only if the output register is free or draining this cycle.
- State LO:
  - On accept, store the nibble plus acc_corr = 1bit|parity and acc_unc = 2bit.
  - Go to HI.
- State HI, accept with in_sof=0:
  - Load out_byte = {in_nibble, low}.
  - out_corrected = acc_corr | in_1bit_error | in_parity_error.
  - out_uncorrectable = acc_unc | in_2bit_error.
  - Set out_valid; go to LO.
  - Latency: byte visible the cycle after the high-nibble accept.
- State HI, accept with in_sof=1:
  - Discard the pending low nibble; the new nibble becomes the low nibble.
  - Stay in HI.
  - Counters still count the discarded nibble's flags.
- in_sof in state LO has no extra effect.
- Output side:
  - out_valid stays high and out_byte and the flags stay stable until out_valid & out_ready.
  - If out_valid & out_ready and a new byte completes in the same cycle, out_valid stays 1 and the new byte loads. No bubble: full throughput of 1 byte per 2 nibble cycles.
  - If it drains with no new byte, out_valid clears.
- Counters:
  - Increment by 1 per accepted nibble, or per delivered byte for cnt_bytes, when the condition holds.
  - A nibble asserting both 1bit and parity increments cnt_corrected once.
  - Each counter holds at all-ones.
  - clr_counts has priority over a same-cycle increment; the result is 0.
- Flags arriving with in_valid=0 are ignored.
- Reset mid-byte drops any pending low nibble and any unread output byte.

Optional Feature:
- Macro HAMMING_DROP_UNCORR_EN.
- Defined:
  - A completed byte with uncorrectable=1 is not loaded into the output register; out_valid is unaffected by it.
  - The byte is never delivered and is not counted in cnt_bytes.
  - cnt_uncorrectable still counts its nibbles.
  - out_uncorrectable is tied to 0.
- Undefined:
  - Uncorrectable bytes are delivered with out_uncorrectable=1.

Test Plan:
1. Reset, out_ready=1, nibbles 0x5 then 0xA, no flags -> out_byte=0xA5, out_valid for 1 cycle, corrected=0, uncorrectable=0, cnt_bytes=1.
2. Low 0x3 with in_1bit_error, high 0xC clean -> out_byte=0xC3, out_corrected=1, cnt_corrected=1; repeat with in_parity_error on the high nibble -> cnt_corrected=2.
3. out_ready=0; send 0x1,0x2 then 0x3 -> byte 0x21 held, 0x3 accepted; next high nibble stalls with in_ready=0. Raise out_ready -> 0x21 drains, and the same cycle's high 0x4 loads 0x43 with no bubble.
4. Low 0x7, then 0x9 with in_sof=1, then 0xE -> out_byte=0xE9; 0x7 never appears.
5. Low nibble with in_2bit_error, high 0x0 -> without macro: out_uncorrectable=1, delivered; with HAMMING_DROP_UNCORR_EN: no out_valid, cnt_bytes unchanged, cnt_uncorrectable=1.
6. CNT_W=2: 4 corrected nibbles -> cnt_corrected=3 saturated; clr_counts concurrent with a corrected nibble -> 0; rst_n low mid-byte (after low nibble) -> next pair assembles from scratch.

Source files
------------

// File: rtl/hamming74_byte_assembler.sv
// Pairs Hamming(7,4) decoded nibbles into bytes (low nibble first) with per-byte error status
// and saturating link-health counters. Optional macro: HAMMING_DROP_UNCORR_EN drops uncorrectable bytes.
module hamming74_byte_assembler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [3:0]       in_nibble,
  input  logic             in_1bit_error,
  input  logic             in_2bit_error,
  input  logic             in_parity_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable,
  output logic [CNT_W-1:0] cnt_bytes
);

  typedef enum logic {LO, HI} state_t;

  state_t state_q, state_d;

  logic [3:0]       lowNibble_q, lowNibble_d;
  logic             accCorr_q, accCorr_d;
  logic             accUnc_q, accUnc_d;
  logic             outValid_q, outValid_d;
  logic [7:0]       outByte_q, outByte_d;
  logic             outCorr_q, outCorr_d;
  logic [CNT_W-1:0] cntCorr_q, cntCorr_d;
  logic [CNT_W-1:0] cntUnc_q, cntUnc_d;
  logic [CNT_W-1:0] cntBytes_q, cntBytes_d;

  logic accept;
  logic captureLow;
  logic completeByte;
  logic loadByte;
  logic drain;
  logic nibCorr;
  logic byteCorr;
  logic byteUnc;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                              input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (v != {CNT_W{1'b1}}))
      return v + 1'b1;
    else
      return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= LO;
    else
      state_q <= state_d;
  end

  // A start-of-frame nibble in HI restarts the byte, so it keeps the FSM in HI.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LO: if (accept) state_d = HI;
      HI: if (accept && !in_sof) state_d = LO;
      default: state_d = LO;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == LO) | ~outValid_q | out_ready;
    accept       = in_valid & in_ready;
    captureLow   = accept & ((state_q == LO) | in_sof);
    completeByte = accept & (state_q == HI) & ~in_sof;
    drain        = outValid_q & out_ready;
    nibCorr      = in_1bit_error | in_parity_error;
    byteCorr     = accCorr_q | nibCorr;
    byteUnc      = accUnc_q | in_2bit_error;
`ifdef HAMMING_DROP_UNCORR_EN
    loadByte     = completeByte & ~byteUnc;
`else
    loadByte     = completeByte;
`endif
  end

  always_comb begin
    lowNibble_d = lowNibble_q;
    accCorr_d   = accCorr_q;
    accUnc_d    = accUnc_q;
    if (captureLow) begin
      lowNibble_d = in_nibble;
      accCorr_d   = nibCorr;
      accUnc_d    = in_2bit_error;
    end
  end

  // Loading wins over draining so a same-cycle handoff keeps out_valid high with no bubble.
  always_comb begin
    outValid_d = outValid_q;
    outByte_d  = outByte_q;
    outCorr_d  = outCorr_q;
    if (loadByte) begin
      outValid_d = 1'b1;
      outByte_d  = {in_nibble, lowNibble_q};
      outCorr_d  = byteCorr;
    end else if (drain) begin
      outValid_d = 1'b0;
    end
  end

  always_comb begin
    cntCorr_d  = satInc(cntCorr_q, accept & nibCorr, clr_counts);
    cntUnc_d   = satInc(cntUnc_q, accept & in_2bit_error, clr_counts);
    cntBytes_d = satInc(cntBytes_q, drain, clr_counts);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowNibble_q <= '0;
      accCorr_q   <= 1'b0;
      accUnc_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outByte_q   <= '0;
      outCorr_q   <= 1'b0;
      cntCorr_q   <= '0;
      cntUnc_q    <= '0;
      cntBytes_q  <= '0;
    end else begin
      lowNibble_q <= lowNibble_d;
      accCorr_q   <= accCorr_d;
      accUnc_q    <= accUnc_d;
      outValid_q  <= outValid_d;
      outByte_q   <= outByte_d;
      outCorr_q   <= outCorr_d;
      cntCorr_q   <= cntCorr_d;
      cntUnc_q    <= cntUnc_d;
      cntBytes_q  <= cntBytes_d;
    end
  end

`ifdef HAMMING_DROP_UNCORR_EN
  assign out_uncorrectable = 1'b0;
`else
  logic outUnc_q, outUnc_d;

  always_comb begin
    outUnc_d = outUnc_q;
    if (loadByte)
      outUnc_d = byteUnc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      outUnc_q <= 1'b0;
    else
      outUnc_q <= outUnc_d;
  end

  assign out_uncorrectable = outUnc_q;
`endif

  assign out_valid         = outValid_q;
  assign out_byte          = outByte_q;
  assign out_corrected     = outCorr_q;
  assign cnt_corrected     = cntCorr_q;
  assign cnt_uncorrectable = cntUnc_q;
  assign cnt_bytes         = cntBytes_q;

endmodule

// File: tb/tb_hamming74_byte_assembler.sv
// Directed bench for hamming74_byte_assembler; a second CNT_W=2 instance shares the stimulus
// so counter saturation can be observed.
module tb_hamming74_byte_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [3:0]  in_nibble;
  logic        in_1bit_error;
  logic        in_2bit_error;
  logic        in_parity_error;
  logic        out_ready;
  logic        clr_counts;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_uncorrectable;
  logic [15:0] cnt_bytes;

  logic        satInReady;
  logic        satOutValid;
  logic [7:0]  satOutByte;
  logic        satOutCorr;
  logic        satOutUnc;
  logic [1:0]  satCntCorr;
  logic [1:0]  satCntUnc;
  logic [1:0]  satCntBytes;

  int testsRun    = 0;
  int testsFailed = 0;
  int expBytes    = 0;

  always #5 clk = ~clk;

  hamming74_byte_assembler #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_nibble(in_nibble),
    .in_1bit_error(in_1bit_error), .in_2bit_error(in_2bit_error),
    .in_parity_error(in_parity_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
    .clr_counts(clr_counts),
    .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable),
    .cnt_bytes(cnt_bytes)
  );

  hamming74_byte_assembler #(.CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(satInReady), .in_sof(in_sof), .in_nibble(in_nibble),
    .in_1bit_error(in_1bit_error), .in_2bit_error(in_2bit_error),
    .in_parity_error(in_parity_error),
    .out_valid(satOutValid), .out_ready(out_ready), .out_byte(satOutByte),
    .out_corrected(satOutCorr), .out_uncorrectable(satOutUnc),
    .clr_counts(clr_counts),
    .cnt_corrected(satCntCorr), .cnt_uncorrectable(satCntUnc),
    .cnt_bytes(satCntBytes)
  );

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one nibble for a single clock edge, then returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [3:0] nib, input logic sof,
                               input logic e1, input logic e2, input logic ep);
    in_valid        = 1'b1;
    in_nibble       = nib;
    in_sof          = sof;
    in_1bit_error   = e1;
    in_2bit_error   = e2;
    in_parity_error = ep;
    @(posedge clk);
    #1;
    in_valid        = 1'b0;
    in_sof          = 1'b0;
    in_1bit_error   = 1'b0;
    in_2bit_error   = 1'b0;
    in_parity_error = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_sof          = 1'b0;
    in_nibble       = 4'h0;
    in_1bit_error   = 1'b0;
    in_2bit_error   = 1'b0;
    in_parity_error = 1'b0;
    out_ready       = 1'b1;
    clr_counts      = 1'b0;

    #22;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_byte", out_byte, 8'h00);
    checkOutput("reset cnt_bytes", cnt_bytes, 0);
    checkOutput("reset cnt_corrected", cnt_corrected, 0);
    checkOutput("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();

    // Plain byte 0x5 then 0xA.
    applyStimulus(4'h5, 0, 0, 0, 0);
    checkOutput("t1 no byte after low", out_valid, 0);
    applyStimulus(4'hA, 0, 0, 0, 0);
    checkOutput("t1 out_valid", out_valid, 1);
    checkOutput("t1 out_byte", out_byte, 8'hA5);
    checkOutput("t1 corrected", out_corrected, 0);
    checkOutput("t1 uncorrectable", out_uncorrectable, 0);
    idleCycle();
    expBytes++;
    checkOutput("t1 out_valid one cycle", out_valid, 0);
    checkOutput("t1 cnt_bytes", cnt_bytes, expBytes);

    // Corrected errors on the low nibble, then parity-only on the high nibble.
    applyStimulus(4'h3, 0, 1, 0, 0);
    applyStimulus(4'hC, 0, 0, 0, 0);
    checkOutput("t2a out_byte", out_byte, 8'hC3);
    checkOutput("t2a corrected", out_corrected, 1);
    checkOutput("t2a cnt_corrected", cnt_corrected, 1);
    idleCycle();
    expBytes++;
    applyStimulus(4'h6, 0, 0, 0, 0);
    applyStimulus(4'h9, 0, 0, 0, 1);
    checkOutput("t2b out_byte", out_byte, 8'h96);
    checkOutput("t2b corrected", out_corrected, 1);
    checkOutput("t2b cnt_corrected", cnt_corrected, 2);
    idleCycle();
    expBytes++;
    checkOutput("t2 cnt_bytes", cnt_bytes, expBytes);

    // Backpressure: held byte, stalled high nibble, then no-bubble handoff.
    out_ready = 1'b0;
    applyStimulus(4'h1, 0, 0, 0, 0);
    applyStimulus(4'h2, 0, 0, 0, 0);
    checkOutput("t3 held valid", out_valid, 1);
    checkOutput("t3 held byte", out_byte, 8'h21);
    applyStimulus(4'h3, 0, 0, 0, 0);
    checkOutput("t3 high stalls", in_ready, 0);
    in_valid  = 1'b1;
    in_nibble = 4'h4;
    idleCycle();
    checkOutput("t3 byte still held", out_byte, 8'h21);
    checkOutput("t3 still stalled", in_ready, 0);
    out_ready = 1'b1;
    #1;
    checkOutput("t3 ready when draining", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expBytes++;
    checkOutput("t3 no bubble valid", out_valid, 1);
    checkOutput("t3 new byte", out_byte, 8'h43);
    checkOutput("t3 cnt_bytes after drain", cnt_bytes, expBytes);
    idleCycle();
    expBytes++;
    checkOutput("t3 drained", out_valid, 0);

    // Start-of-frame on a would-be high nibble restarts the byte.
    applyStimulus(4'h7, 0, 0, 0, 0);
    applyStimulus(4'h9, 1, 0, 0, 0);
    checkOutput("t4 sof no byte", out_valid, 0);
    applyStimulus(4'hE, 0, 0, 0, 0);
    checkOutput("t4 out_byte", out_byte, 8'hE9);
    idleCycle();
    expBytes++;
    checkOutput("t4 cnt_bytes", cnt_bytes, expBytes);

    // Uncorrectable low nibble.
    applyStimulus(4'hD, 0, 0, 1, 0);
    applyStimulus(4'h0, 0, 0, 0, 0);
`ifdef HAMMING_DROP_UNCORR_EN
    checkOutput("t5 dropped", out_valid, 0);
    checkOutput("t5 out_unc tied", out_uncorrectable, 0);
`else
    checkOutput("t5 delivered", out_valid, 1);
    checkOutput("t5 out_byte", out_byte, 8'h0D);
    checkOutput("t5 uncorrectable", out_uncorrectable, 1);
    expBytes++;
`endif
    checkOutput("t5 cnt_uncorrectable", cnt_uncorrectable, 1);
    idleCycle();
    checkOutput("t5 cnt_bytes", cnt_bytes, expBytes);

    // Saturation on the CNT_W=2 instance, clear priority, and reset mid-byte.
    clr_counts = 1'b1;
    idleCycle();
    clr_counts = 1'b0;
    checkOutput("t6 cleared", satCntCorr, 0);
    checkOutput("t6 cleared bytes", cnt_bytes, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(4'h1, 0, 1, 0, 0);
    checkOutput("t6 sat cnt_corrected", satCntCorr, 3);
    checkOutput("t6 wide cnt_corrected", cnt_corrected, 4);
    checkOutput("t6 sat byte", satOutByte, 8'h11);
    clr_counts = 1'b1;
    applyStimulus(4'h2, 0, 1, 0, 0);
    clr_counts = 1'b0;
    checkOutput("t6 clr priority sat", satCntCorr, 0);
    checkOutput("t6 clr priority wide", cnt_corrected, 0);
    #2;
    rst_n = 1'b0;
    #2;
    checkOutput("t6 reset out_valid", out_valid, 0);
    checkOutput("t6 reset cnt_bytes", cnt_bytes, 0);
    rst_n = 1'b1;
    idleCycle();
    applyStimulus(4'h8, 0, 0, 0, 0);
    checkOutput("t6 fresh low no byte", out_valid, 0);
    applyStimulus(4'hF, 0, 0, 0, 0);
    checkOutput("t6 fresh byte", out_byte, 8'hF8);
    checkOutput("t6 fresh byte sat inst", satOutByte, 8'hF8);
    checkOutput("t6 fresh corrected", out_corrected, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
